// File: rtl/conv_code_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its matching decoder.
// Generator tables are indexed directly by constraint length K.
package conv_code_pkg;
    localparam int FRAME_LEN = 16;
    localparam int K_MIN     = 3;
    localparam int K_MAX     = 6;
    localparam int SR_W      = K_MAX - 1;
    localparam int CNT_W     = 5;

    typedef logic [K_MAX-1:0] gen_t;

    // Tap bit 0 is the current input; tap n is the input n steps earlier.
    localparam gen_t G0_TAB [K_MIN:K_MAX] = '{6'o07, 6'o15, 6'o23, 6'o53};
    localparam gen_t G1_TAB [K_MIN:K_MAX] = '{6'o05, 6'o17, 6'o35, 6'o75};

    typedef enum logic [1:0] {IDLE, ENC, TAIL} enc_state_t;

    function automatic logic [2:0] clamp_k(input logic [2:0] k);
        if (k < 3'd3) return 3'd3;
        if (k > 3'd6) return 3'd6;
        return k;
    endfunction

    function automatic logic [SR_W-1:0] sr_mask(input logic [2:0] k);
        case (k)
            3'd3:    return 5'b00011;
            3'd4:    return 5'b00111;
            3'd5:    return 5'b01111;
            default: return 5'b11111;
        endcase
    endfunction

    function automatic logic [SR_W-1:0] shift_sr(input logic [SR_W-1:0] s,
                                                 input logic            b,
                                                 input logic [2:0]      k);
        return {s[SR_W-2:0], b} & sr_mask(k);
    endfunction
endpackage

// File: rtl/conv_enc_core.sv
// Combinational symbol generator: {g0, g1} parity of the input bit and state register.
// Zero latency; no handshake of its own.
module conv_enc_core
    import conv_code_pkg::*;
(
    input  logic            in_bit,
    input  logic [SR_W-1:0] sr,
    input  logic [2:0]      k,
    output logic [1:0]      sym
);
    logic [K_MAX-1:0] taps;
    logic [K_MAX-1:0] g0;
    logic [K_MAX-1:0] g1;

    always_comb begin
        taps = {sr & sr_mask(k), in_bit};
        g0   = G0_TAB[k];
        g1   = G1_TAB[k];
        sym  = {^(taps & g0), ^(taps & g1)};
    end
endmodule

// File: rtl/conv_encoder_sys.sv
// Rate-1/2 convolutional encoder, K 3..6, 16-bit frames serialized MSB first; CONV_ENC_TAIL_EN adds zero-tail.
// Latency: first registered symbol one cycle after frame acceptance, then one symbol per enc_ready cycle.
// Backpressure: all state and outputs hold while enc_valid && !enc_ready; data_ready only in IDLE.
module conv_encoder_sys
    import conv_code_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           choose_constraint_length,
    input  logic [FRAME_LEN-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [1:0]           encoded_bits,
    output logic                 enc_valid,
    input  logic                 enc_ready,
    output logic                 enc_last
);
`ifdef CONV_ENC_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    enc_state_t           state, state_nxt;
    logic [FRAME_LEN-1:0] shift_buf, buf_nxt;
    logic [SR_W-1:0]      sr, sr_nxt;
    logic [2:0]           k_reg, k_nxt;
    logic [CNT_W-1:0]     bit_cnt, cnt_nxt, cnt_inc;
    logic                 vld_nxt, last_nxt, in_nxt;
    logic [1:0]           sym;

    assign cnt_inc    = bit_cnt + 5'd1;
    assign data_ready = (state == IDLE);

`ifdef CONV_ENC_TAIL_EN
    logic [CNT_W-1:0] tail_end;
    assign tail_end = CNT_W'(k_reg) - 5'd2;
`endif

    // Next-state values feed the core, so the registered symbol always matches the registered state.
    always_comb begin
        state_nxt = state;
        buf_nxt   = shift_buf;
        sr_nxt    = sr;
        k_nxt     = k_reg;
        cnt_nxt   = bit_cnt;
        vld_nxt   = enc_valid;
        last_nxt  = enc_last;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    state_nxt = ENC;
                    buf_nxt   = data_in;
                    sr_nxt    = '0;
                    k_nxt     = clamp_k(choose_constraint_length);
                    cnt_nxt   = '0;
                end
            end
            ENC: begin
                if (!enc_valid) begin
                    vld_nxt  = 1'b1;
                    last_nxt = !TAIL_EN && (bit_cnt == LAST_BIT);
                end else if (enc_ready) begin
                    sr_nxt  = shift_sr(sr, shift_buf[FRAME_LEN-1], k_reg);
                    buf_nxt = shift_buf << 1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef CONV_ENC_TAIL_EN
                        state_nxt = TAIL;
                        cnt_nxt   = '0;
                        last_nxt  = (tail_end == '0);
`else
                        state_nxt = IDLE;
                        cnt_nxt   = cnt_inc;
                        vld_nxt   = 1'b0;
                        last_nxt  = 1'b0;
`endif
                    end else begin
                        cnt_nxt  = cnt_inc;
                        last_nxt = !TAIL_EN && (cnt_inc == LAST_BIT);
                    end
                end
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL: begin
                if (enc_ready) begin
                    sr_nxt = shift_sr(sr, 1'b0, k_reg);
                    if (bit_cnt == tail_end) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        last_nxt  = 1'b0;
                    end else begin
                        cnt_nxt  = cnt_inc;
                        last_nxt = (cnt_inc == tail_end);
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        in_nxt = (state_nxt == TAIL) ? 1'b0 : buf_nxt[FRAME_LEN-1];
    end

    conv_enc_core u_core (
        .in_bit (in_nxt),
        .sr     (sr_nxt),
        .k      (k_nxt),
        .sym    (sym)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_buf    <= '0;
            sr           <= '0;
            k_reg        <= 3'd3;
            bit_cnt      <= '0;
            enc_valid    <= 1'b0;
            enc_last     <= 1'b0;
            encoded_bits <= 2'b00;
        end else begin
            state        <= state_nxt;
            shift_buf    <= buf_nxt;
            sr           <= sr_nxt;
            k_reg        <= k_nxt;
            bit_cnt      <= cnt_nxt;
            enc_valid    <= vld_nxt;
            enc_last     <= last_nxt;
            encoded_bits <= vld_nxt ? sym : 2'b00;
        end
    end
endmodule

// File: tb/tb_conv_encoder_sys.sv
// Directed bench for conv_encoder_sys; expectations adapt to CONV_ENC_TAIL_EN.
module tb_conv_encoder_sys;
`ifdef CONV_ENC_TAIL_EN
    localparam bit TAIL = 1'b1;
`else
    localparam bit TAIL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  choose_constraint_length = 3'd3;
    logic [15:0] data_in = 16'h0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [1:0]  encoded_bits;
    logic        enc_valid;
    logic        enc_ready = 1'b0;
    logic        enc_last;

    int n_vec = 0;
    int n_miss = 0;
    logic [1:0] got_sym[$];
    logic       got_last[$];
    int   vld_cycles, first_lat, stall_err;
    logic rdy_after_acc;

    conv_encoder_sys dut (
        .clk                      (clk),
        .rst                      (rst),
        .choose_constraint_length (choose_constraint_length),
        .data_in                  (data_in),
        .data_valid               (data_valid),
        .data_ready               (data_ready),
        .encoded_bits             (encoded_bits),
        .enc_valid                (enc_valid),
        .enc_ready                (enc_ready),
        .enc_last                 (enc_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Offers one frame and collects handshaken symbols until enc_last or max_syms.
    task automatic drive_frame(input logic [2:0] k, input logic [15:0] d, input bit rnd,
                               input bit noise, input int max_syms);
        bit stalled = 0;
        bit seen = 0;
        bit done = 0;
        logic [1:0] hold_b = 2'b00;
        logic hold_l = 1'b0;
        int cyc = 0;
        got_sym.delete();
        got_last.delete();
        vld_cycles = 0;
        first_lat = -1;
        stall_err = 0;
        while (data_ready !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        choose_constraint_length = k;
        data_in = d;
        data_valid = 1'b1;
        @(posedge clk); #1;
        rdy_after_acc = data_ready;
        if (noise) begin
            data_in = ~d;
            choose_constraint_length = 3'd6;
        end
        cyc = 0;
        while (!done && cyc < 300) begin
            data_valid = noise && (got_sym.size() < 4);
            if (stalled && (enc_valid !== 1'b1 || encoded_bits !== hold_b || enc_last !== hold_l))
                stall_err++;
            if (enc_valid === 1'b1 && !seen) begin
                seen = 1;
                first_lat = cyc;
            end
            if (seen) vld_cycles++;
            enc_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (enc_valid === 1'b1 && enc_ready) begin
                got_sym.push_back(encoded_bits);
                got_last.push_back(enc_last);
                if (enc_last === 1'b1 || got_sym.size() >= max_syms) done = 1;
            end
            stalled = (enc_valid === 1'b1) && !enc_ready;
            hold_b = encoded_bits;
            hold_l = enc_last;
            @(posedge clk); #1; cyc++;
        end
        data_valid = 1'b0;
        enc_ready = 1'b0;
        n_vec++;
        if (!done) begin
            n_miss++;
            $display("FAIL frame_timeout got %0d symbols before cycle budget", got_sym.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (data_ready !== 1'b1) begin n_miss++; $display("FAIL reset_data_ready got %b want 1", data_ready); end
        n_vec++; if (enc_valid !== 1'b0) begin n_miss++; $display("FAIL reset_enc_valid got %b want 0", enc_valid); end
        n_vec++; if (encoded_bits !== 2'b00) begin n_miss++; $display("FAIL reset_encoded_bits got %b want 00", encoded_bits); end
        n_vec++; if (enc_last !== 1'b0) begin n_miss++; $display("FAIL reset_enc_last got %b want 0", enc_last); end
        rst = 1'b0;
    endtask

    task automatic test_k3_impulse();
        logic [1:0] want[$];
        want = '{2'b11, 2'b10, 2'b11};
        repeat (13) want.push_back(2'b00);
        if (TAIL) repeat (2) want.push_back(2'b00);
        drive_frame(3'd3, 16'h8000, 1'b0, 1'b0, 100);
        n_vec++; if (data_ready !== 1'b1) begin n_miss++; $display("FAIL k3i_ready_after_last got %b want 1", data_ready); end
        n_vec++; if (rdy_after_acc !== 1'b0) begin n_miss++; $display("FAIL k3i_ready_busy got %b want 0", rdy_after_acc); end
        n_vec++; if (first_lat != 1) begin n_miss++; $display("FAIL k3i_latency got %0d want 1", first_lat); end
        n_vec++; if (vld_cycles != want.size()) begin n_miss++; $display("FAIL k3i_cycles got %0d want %0d", vld_cycles, want.size()); end
        n_vec++; if (got_sym.size() != want.size()) begin n_miss++; $display("FAIL k3i_len got %0d want %0d", got_sym.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL k3i_sym%0d got %b want %b", i, got_sym[i], want[i]); end
            n_vec++; if (got_last[i] !== (i == want.size() - 1)) begin n_miss++; $display("FAIL k3i_last%0d got %b", i, got_last[i]); end
        end
        @(posedge clk); #1;
        n_vec++; if (data_ready !== 1'b1) begin n_miss++; $display("FAIL k3i_ready_idle got %b want 1", data_ready); end
    endtask

    task automatic test_k3_ones();
        logic [1:0] want[$];
        want = '{2'b11, 2'b01};
        repeat (14) want.push_back(2'b10);
        if (TAIL) begin
            want.push_back(2'b01);
            want.push_back(2'b11);
        end
        drive_frame(3'd3, 16'hFFFF, 1'b0, 1'b0, 100);
        n_vec++; if (got_sym.size() != want.size()) begin n_miss++; $display("FAIL k3o_len got %0d want %0d", got_sym.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL k3o_sym%0d got %b want %b", i, got_sym[i], want[i]); end
            n_vec++; if (got_last[i] !== (i == want.size() - 1)) begin n_miss++; $display("FAIL k3o_last%0d got %b", i, got_last[i]); end
        end
    endtask

    task automatic test_k_clamp();
        logic [1:0] want[$];
        want = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11};
        repeat (10) want.push_back(2'b00);
        if (TAIL) repeat (5) want.push_back(2'b00);
        drive_frame(3'd7, 16'h8000, 1'b0, 1'b0, 100);
        n_vec++; if (got_sym.size() != want.size()) begin n_miss++; $display("FAIL k7_len got %0d want %0d", got_sym.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL k7_sym%0d got %b want %b", i, got_sym[i], want[i]); end
            n_vec++; if (got_last[i] !== (i == want.size() - 1)) begin n_miss++; $display("FAIL k7_last%0d got %b", i, got_last[i]); end
        end
        want = '{2'b11, 2'b10, 2'b11};
        drive_frame(3'd1, 16'h8000, 1'b0, 1'b0, 100);
        n_vec++; if (got_sym.size() != (TAIL ? 18 : 16)) begin n_miss++; $display("FAIL k1_len got %0d want %0d", got_sym.size(), TAIL ? 18 : 16); end
        for (int i = 0; i < 3 && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL k1_sym%0d got %b want %b", i, got_sym[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] want[$];
        want = '{2'b11, 2'b01};
        repeat (14) want.push_back(2'b10);
        if (TAIL) begin
            want.push_back(2'b01);
            want.push_back(2'b11);
        end
        drive_frame(3'd3, 16'hFFFF, 1'b1, 1'b1, 100);
        n_vec++; if (stall_err != 0) begin n_miss++; $display("FAIL bp_stall_hold got %0d unstable stall cycles want 0", stall_err); end
        n_vec++; if (got_sym.size() != want.size()) begin n_miss++; $display("FAIL bp_len got %0d want %0d", got_sym.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL bp_sym%0d got %b want %b", i, got_sym[i], want[i]); end
            n_vec++; if (got_last[i] !== (i == want.size() - 1)) begin n_miss++; $display("FAIL bp_last%0d got %b", i, got_last[i]); end
        end
    endtask

    task automatic test_midframe_reset();
        logic [1:0] want[$];
        drive_frame(3'd4, 16'hA5C3, 1'b0, 1'b0, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (enc_valid !== 1'b0) begin n_miss++; $display("FAIL mrst_enc_valid got %b want 0", enc_valid); end
        n_vec++; if (data_ready !== 1'b1) begin n_miss++; $display("FAIL mrst_data_ready got %b want 1", data_ready); end
        n_vec++; if (encoded_bits !== 2'b00 || enc_last !== 1'b0) begin n_miss++; $display("FAIL mrst_outputs got bits=%b last=%b want 00/0", encoded_bits, enc_last); end
        want = '{2'b11, 2'b10, 2'b11};
        drive_frame(3'd3, 16'h8000, 1'b0, 1'b0, 100);
        n_vec++; if (got_sym.size() != (TAIL ? 18 : 16)) begin n_miss++; $display("FAIL mrst_len got %0d want %0d", got_sym.size(), TAIL ? 18 : 16); end
        for (int i = 0; i < 3 && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL mrst_sym%0d got %b want %b", i, got_sym[i], want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want[$];
        repeat (15) want.push_back(2'b00);
        want.push_back(2'b11);
        if (TAIL) begin
            want.push_back(2'b01);
            want.push_back(2'b11);
            want.push_back(2'b11);
        end
        drive_frame(3'd4, 16'h0001, 1'b0, 1'b0, 100);
        n_vec++; if (data_ready !== 1'b1) begin n_miss++; $display("FAIL k4_ready_after_last got %b want 1", data_ready); end
        n_vec++; if (got_sym.size() != want.size()) begin n_miss++; $display("FAIL k4_len got %0d want %0d", got_sym.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL k4_sym%0d got %b want %b", i, got_sym[i], want[i]); end
            n_vec++; if (got_last[i] !== (i == want.size() - 1)) begin n_miss++; $display("FAIL k4_last%0d got %b", i, got_last[i]); end
        end
        want = '{2'b11, 2'b10, 2'b11};
        drive_frame(3'd3, 16'h8000, 1'b0, 1'b0, 100);
        n_vec++; if (first_lat != 1) begin n_miss++; $display("FAIL b2b_latency got %0d want 1", first_lat); end
        for (int i = 0; i < 3 && i < got_sym.size(); i++) begin
            n_vec++; if (got_sym[i] !== want[i]) begin n_miss++; $display("FAIL b2b_sym%0d got %b want %b", i, got_sym[i], want[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_k3_impulse();
        test_k3_ones();
        test_k_clamp();
        test_backpressure();
        test_midframe_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
